// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data memory for the multicycle MIPS datapath.
// Handles byte/halfword/word stores through lane enables and sign- or
// zero-extended sub-word loads. Each access is a req/ack handshake with
// WAIT extra wait states, and misaligned accesses are flagged on err.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req, we, size, uns  request and its attributes, sampled in IDLE only
//   addr, wd            byte address (wraps above bit AW+1), right-aligned store data
//   rd                  registered load result, held between acks
//   ack, err            one-cycle completion pulse, misalignment flag
//   busy                high whenever an access is in flight
//
// state  | meaning
// IDLE   | waiting for req, captures the request
// ACCESS | counting down wait states, commits the access when cnt reaches 0
// RESP   | ack (and err if misaligned) for one cycle
module dmem_ctrl #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic            we_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wd_q;
  logic            mis_q;
  logic            mis_in;
  logic            commit;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     word_q;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_val;
  logic [3:0]      be;
  logic [31:0]     wdata;

  // High address bits are deliberately ignored so the address wraps.
  logic unused_addr;
  assign unused_addr = ^addr[31:AW+2];

  always_comb begin
    mis_in = (size == 2'b11)
           || (size == 2'b01 && addr[0])
           || (size == 2'b10 && addr[1:0] != 2'b00);
  end

  assign commit = (state == ACCESS) && (cnt == 4'd0);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    ack  = (state == RESP);
    err  = (state == RESP) && mis_q;
    busy = (state != IDLE);
  end

  // request capture, wait-state down-counter and load result
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      we_q   <= 1'b0;
      size_q <= '0;
      uns_q  <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      mis_q  <= 1'b0;
      rd     <= '0;
    end else begin
      if (state == IDLE && req) begin
        we_q   <= we;
        size_q <= size;
        uns_q  <= uns;
        addr_q <= addr[AW+1:0];
        wd_q   <= wd;
        mis_q  <= mis_in;
        cnt    <= WAIT_LD;
      end else if (state == ACCESS && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) rd <= load_val;
    end
  end

  assign word_q   = mem[addr_q[AW+1:2]];
  assign byte_sel = word_q[{addr_q[1:0], 3'b000} +: 8];
  assign half_sel = addr_q[1] ? word_q[31:16] : word_q[15:0];

  // Stores and misaligned accesses return zero.
  always_comb begin
    load_val = '0;
    if (!we_q && !mis_q) begin
      case (size_q)
        2'b00:   load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
        2'b01:   load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
        2'b10:   load_val = word_q;
        default: load_val = '0;
      endcase
    end
  end

  // Sub-word data is replicated across lanes; be picks the lanes that land.
  always_comb begin
    be    = 4'b0000;
    wdata = wd_q;
    case (size_q)
      2'b00: begin
        be    = 4'b0001 << addr_q[1:0];
        wdata = {4{wd_q[7:0]}};
      end
      2'b01: begin
        be    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{wd_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && commit && we_q && !mis_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr_q[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  logic        clk;
  logic        reset_v [2];
  logic        req_v   [2];
  logic        we_v    [2];
  logic [1:0]  size_v  [2];
  logic        uns_v   [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wd_v    [2];
  logic [31:0] rd_v    [2];
  logic        ack_v   [2];
  logic        err_v   [2];
  logic        busy_v  [2];

  int n_checks = 0;
  int n_errors = 0;

  // reference memory image per instance, one word per entry
  logic [31:0] mdl [2][64];

  dmem_ctrl #(.DEPTH(64), .WAIT(0)) dut0 (
    .clk(clk), .reset(reset_v[0]), .req(req_v[0]), .we(we_v[0]),
    .size(size_v[0]), .uns(uns_v[0]), .addr(addr_v[0]), .wd(wd_v[0]),
    .rd(rd_v[0]), .ack(ack_v[0]), .err(err_v[0]), .busy(busy_v[0])
  );

  dmem_ctrl #(.DEPTH(64), .WAIT(3)) dut3 (
    .clk(clk), .reset(reset_v[1]), .req(req_v[1]), .we(we_v[1]),
    .size(size_v[1]), .uns(uns_v[1]), .addr(addr_v[1]), .wd(wd_v[1]),
    .rd(rd_v[1]), .ack(ack_v[1]), .err(err_v[1]), .busy(busy_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Applies one access to the reference image and returns what rd/err should show.
  function automatic void model_access(input int d, input logic w, input logic [1:0] sz,
                                       input logic u, input logic [31:0] a, input logic [31:0] data,
                                       output logic [31:0] exp_rd, output logic exp_err);
    int unsigned idx;
    int unsigned sh;
    logic [31:0] v;
    logic mis;
    idx = (a / 4) % 64;
    sh  = 8 * (a % 4);
    mis = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    exp_rd  = 32'h0;
    exp_err = mis;
    if (mis) return;
    if (w) begin
      case (sz)
        2'd0: mdl[d][idx] = (mdl[d][idx] & ~(32'hFF << sh)) | ((data & 32'hFF) << sh);
        2'd1: mdl[d][idx] = (mdl[d][idx] & ~(32'hFFFF << sh)) | ((data & 32'hFFFF) << sh);
        default: mdl[d][idx] = data;
      endcase
    end else begin
      case (sz)
        2'd0: begin
          v = (mdl[d][idx] >> sh) & 32'hFF;
          if (!u && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end
        2'd1: begin
          v = (mdl[d][idx] >> sh) & 32'hFFFF;
          if (!u && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end
        default: v = mdl[d][idx];
      endcase
      exp_rd = v;
    end
  endfunction

  task automatic scramble(input int d);
    we_v[d]   = 1'($urandom);
    size_v[d] = 2'($urandom);
    uns_v[d]  = 1'($urandom);
    addr_v[d] = $urandom;
    wd_v[d]   = $urandom;
  endtask

  // One complete access; inputs other than req are scrambled while it is in flight.
  task automatic do_acc(input int d, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] data, input string tag,
                        output logic [31:0] obs_rd);
    logic [31:0] exp_rd;
    logic exp_err;
    int ack_cyc;
    model_access(d, w, sz, u, a, data, exp_rd, exp_err);
    @(negedge clk);
    check_val({tag, "_idle_busy"}, {31'b0, busy_v[d]}, 32'd0);
    check_val({tag, "_idle_ack"}, {31'b0, ack_v[d]}, 32'd0);
    req_v[d] = 1'b1; we_v[d] = w; size_v[d] = sz; uns_v[d] = u; addr_v[d] = a; wd_v[d] = data;
    ack_cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_v[d] = 1'b0;
      scramble(d);
      check_val({tag, "_busy"}, {31'b0, busy_v[d]}, 32'd1);
      if (ack_v[d]) begin
        ack_cyc = k;
        break;
      end
      check_val({tag, "_err_noack"}, {31'b0, err_v[d]}, 32'd0);
    end
    check_val({tag, "_ack_cycle"}, ack_cyc, wait_of(d) + 2);
    check_val({tag, "_rd"}, rd_v[d], exp_rd);
    check_val({tag, "_err"}, {31'b0, err_v[d]}, {31'b0, exp_err});
    obs_rd = rd_v[d];
  endtask

  task automatic held_req_test(input logic [31:0] a);
    int acks[$];
    logic [31:0] e1;
    logic er;
    model_access(1, 1'b0, 2'd2, 1'b0, a, 32'h0, e1, er);
    @(negedge clk);
    req_v[1] = 1'b1; we_v[1] = 1'b0; size_v[1] = 2'd2; uns_v[1] = 1'b0; addr_v[1] = a; wd_v[1] = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 12) req_v[1] = 1'b0;
      if (ack_v[1]) begin
        acks.push_back(k);
        check_val("held_rd", rd_v[1], e1);
      end
      if (k == 6) check_val("held_idle_c6", {31'b0, busy_v[1]}, 32'd0);
      if (k == 7) check_val("held_busy_c7", {31'b0, busy_v[1]}, 32'd1);
    end
    check_val("held_nacks", acks.size(), 32'd2);
    if (acks.size() == 2) begin
      check_val("held_ack1", acks[0], 32'd5);
      check_val("held_ack2", acks[1], 32'd11);
    end
  endtask

  task automatic reset_mid_test();
    @(negedge clk);
    req_v[1] = 1'b1; we_v[1] = 1'b1; size_v[1] = 2'd2; uns_v[1] = 1'b0;
    addr_v[1] = 32'h30; wd_v[1] = 32'hCAFE_F00D;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req_v[1] = 1'b0;
      check_val("rst_mid_noack", {31'b0, ack_v[1]}, 32'd0);
      if (k == 4) reset_v[1] = 1'b1;
    end
    @(negedge clk);
    check_val("rst_mid_ack", {31'b0, ack_v[1]}, 32'd0);
    check_val("rst_mid_busy", {31'b0, busy_v[1]}, 32'd0);
    check_val("rst_mid_rd", rd_v[1], 32'd0);
    reset_v[1] = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0] sz;
    logic [31:0] a;
    int d;
    for (int i = 0; i < 2; i++) begin
      reset_v[i] = 1'b1; req_v[i] = 1'b0; we_v[i] = 1'b0; size_v[i] = 2'd0;
      uns_v[i] = 1'b0; addr_v[i] = 32'h0; wd_v[i] = 32'h0;
      for (int j = 0; j < 64; j++) mdl[i][j] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_val("rst_rd", rd_v[i], 32'd0);
      check_val("rst_ack", {31'b0, ack_v[i]}, 32'd0);
      check_val("rst_err", {31'b0, err_v[i]}, 32'd0);
      check_val("rst_busy", {31'b0, busy_v[i]}, 32'd0);
    end
    reset_v[0] = 1'b0; reset_v[1] = 1'b0;

    // word traffic
    do_acc(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, "sw10", r);
    do_acc(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "lw10", r);
    check_val("lw10_const", r, 32'hDEAD_BEEF);

    // sub-word stores and loads
    do_acc(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, "sw20", r);
    do_acc(0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AA, "sb21", r);
    do_acc(0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_8001, "sh22", r);
    do_acc(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "lw20", r);
    check_val("lw20_const", r, 32'h8001_AA44);
    do_acc(0, 1'b0, 2'd0, 1'b0, 32'h21, 32'h0, "lb21", r);
    check_val("lb21_const", r, 32'hFFFF_FFAA);
    do_acc(0, 1'b0, 2'd0, 1'b1, 32'h21, 32'h0, "lbu21", r);
    check_val("lbu21_const", r, 32'h0000_00AA);
    do_acc(0, 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, "lh22", r);
    check_val("lh22_const", r, 32'hFFFF_8001);
    do_acc(0, 1'b0, 2'd1, 1'b1, 32'h22, 32'h0, "lhu22", r);
    check_val("lhu22_const", r, 32'h0000_8001);

    // misalignment
    do_acc(0, 1'b1, 2'd2, 1'b0, 32'h0C, 32'h1234_5678, "sw0c", r);
    do_acc(0, 1'b1, 2'd1, 1'b0, 32'h0D, 32'hFFFF_FFFF, "sh0d_mis", r);
    do_acc(0, 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0, "lw0c_after", r);
    check_val("lw0c_const", r, 32'h1234_5678);
    do_acc(0, 1'b0, 2'd2, 1'b0, 32'h0E, 32'h0, "lw0e_mis", r);
    do_acc(0, 1'b0, 2'd3, 1'b0, 32'h0C, 32'h0, "sz3_mis", r);

    // wrap
    do_acc(0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h5A5A_5A5A, "sw_wrap", r);
    do_acc(0, 1'b0, 2'd2, 1'b0, 32'h000, 32'h0, "lw_wrap", r);
    check_val("lw_wrap_const", r, 32'h5A5A_5A5A);

    // wait states, held req, reset mid-store
    do_acc(1, 1'b1, 2'd2, 1'b0, 32'h44, 32'h0BAD_F00D, "w3_sw44", r);
    do_acc(1, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, "w3_lw44", r);
    held_req_test(32'h44);
    do_acc(1, 1'b1, 2'd2, 1'b0, 32'h30, 32'h0, "w3_sw30_zero", r);
    reset_mid_test();
    do_acc(1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, "w3_lw30_after_rst", r);
    check_val("lw30_const", r, 32'h0);

    // fill both memories, then random traffic
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 64; j++)
        do_acc(i, 1'b1, 2'd2, 1'b0, 32'(j * 4), $urandom, "fill", r);
    for (int n = 0; n < 300; n++) begin
      d  = int'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_acc(d, 1'($urandom), sz, 1'($urandom), a, $urandom, "rand", r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data memory for the multicycle MIPS datapath, replacing the single-cycle word-only data RAM. Supports byte, halfword and word stores through lane enables, plus sign- or zero-extended sub-word loads. It has a configurable number of wait states behind a req/ack handshake and flags misaligned accesses instead of silently truncating the address. It sits between the datapath's memory stage and the load/store control FSM.

## Interface
- DEPTH, 64: memory depth in 32-bit words; power of two, 4..65536; AW = clog2(DEPTH).
- WAIT, 0: extra wait-state cycles per access, 0..15.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load; captured with req.
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- uns  in  1  1 = zero-extend sub-word load, 0 = sign-extend; ignored for stores and words.
- addr  in  32  byte address; word index = addr[AW+1:2]; bits above AW+1 ignored (address wraps).
- wd  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rd  out  32  registered load result; valid while ack=1, held until the next ack.
- ack  out  1  one-cycle completion pulse.
- err  out  1  misalignment flag; only ever high together with ack.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If req=1, capture we, size, uns, addr and wd.
  - Load the wait counter cnt with WAIT and go to ACCESS.
  - Compute the misaligned flag from the captured values.
- Misaligned when:
  - size=01 and addr[0]=1;
  - size=10 and addr[1:0]≠00;
  - size=11 (any address).
- ACCESS:
  - If cnt≠0, decrement cnt and stay.
  - If cnt=0, perform the access at this edge and go to RESP.
- Store lane rules (a misaligned store writes nothing):
  - Byte store: writes wd[7:0] into byte lane addr[1:0] only.
  - Halfword store: writes wd[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - Word store: writes all 4 lanes.
  - Other lanes are unchanged.
- Loads (registered into rd):
  - Byte load: select lane addr[1:0], then extend per uns.
  - Halfword load: select half addr[1], then extend per uns.
  - Word load: full word.
  - Misaligned load: rd ← 0.
- Stores and misaligned accesses also update rd: rd ← 0 at completion.
- RESP: ack=1, err = captured misaligned flag; go to IDLE unconditionally. req is ignored in ACCESS and RESP.
- Memory array contents are not reset and are undefined until written.

## Timing
- Define cycle 0 as the IDLE cycle in which req=1. The ACCESS commit edge is the end of cycle WAIT+1, and ack=1 during cycle WAIT+2.
- With WAIT=0, ack is in cycle 2. Throughput is one access per WAIT+3 cycles.
- A store is visible to a load accepted in any later IDLE cycle; there is no forwarding path needed.
- busy=1 from cycle 1 through cycle WAIT+2 inclusive.
- If req is still high in the IDLE cycle after ack, it starts a new access.
- Reset (synchronous):
  - state ← IDLE, cnt ← 0, rd ← 0, ack ← 0, err ← 0, busy ← 0.
  - Reset has priority over everything. No write commits on an edge where reset=1, so an in-flight store is aborted and no ack is produced for it.
- Boundary conditions:
  - WAIT=0 skips the decrement path entirely.
  - An address with index DEPTH-1+1 wraps to word 0.
  - addr bits above AW+1 never cause an error.

## Test plan
- Reset then word traffic, DEPTH=64, WAIT=0: store 0xDEADBEEF at 0x10, then load at 0x10 → ack in cycle 2 of each access, rd=0xDEADBEEF, err=0, busy high for cycles 1–2.
- Byte/half stores and loads:
  - Store word 0x11223344 at 0x20, sb 0xAA at 0x21, sh 0x8001 at 0x22.
  - Word load → 0x8001AA44.
  - lb 0x21 → 0xFFFFFFAA; lbu 0x21 → 0x000000AA.
  - lh 0x22 → 0xFFFF8001; lhu 0x22 → 0x00008001.
- Misalignment, with word 0x0C holding 0x12345678:
  - sh to 0x0D → ack and err=1 together, rd=0, word at 0x0C still 0x12345678.
  - lw at 0x0E → err=1, rd=0.
  - size=11 at 0x0C → err=1.
- Wait states, WAIT=3:
  - Load accepted in cycle 0 → ack in cycle 5 only.
  - req held high throughout → next access accepted in cycle 6.
  - Changing addr/wd during cycles 1–4 has no effect.
- Reset mid-operation, WAIT=3: start sw of 0xCAFEF00D to 0x30 (previously 0), assert reset in cycle 4 → no ack, busy=0 next cycle, subsequent lw 0x30 returns 0.
- Wrap, DEPTH=64: sw 0x5A5A5A5A to 0x100 → lw 0x000 returns 0x5A5A5A5A with err=0.
